// File: rtl/wb_arbiter_rr.sv
// Round-robin Wishbone arbiter: N masters share one slave, grant held per CYC.
// Define WB_ARB_TIMEOUT_EN to add a watchdog that ends hung cycles with ERR.
module wb_arbiter_rr #(
    parameter int N_MASTERS      = 4,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_MASTERS-1:0]                   m_cyc,
    input  logic [N_MASTERS-1:0]                   m_stb,
    input  logic [N_MASTERS-1:0]                   m_we,
    input  logic [N_MASTERS*WB_ADDR_WIDTH-1:0]     m_adr,
    input  logic [N_MASTERS*WB_DATA_WIDTH-1:0]     m_dat_w,
    input  logic [N_MASTERS*(WB_DATA_WIDTH/8)-1:0] m_sel,
    input  logic [N_MASTERS*3-1:0]                 m_cti,
    input  logic [N_MASTERS*2-1:0]                 m_bte,
    output logic [N_MASTERS-1:0]                   m_ack,
    output logic [N_MASTERS-1:0]                   m_err,
    output logic [WB_DATA_WIDTH-1:0]               m_dat_r,
    output logic                                   s_cyc,
    output logic                                   s_stb,
    output logic                                   s_we,
    output logic [WB_ADDR_WIDTH-1:0]               s_adr,
    output logic [WB_DATA_WIDTH-1:0]               s_dat_w,
    output logic [WB_DATA_WIDTH/8-1:0]             s_sel,
    output logic [2:0]                             s_cti,
    output logic [1:0]                             s_bte,
    input  logic                                   s_ack,
    input  logic                                   s_err,
    input  logic [WB_DATA_WIDTH-1:0]               s_dat_r,
    output logic [N_MASTERS-1:0]                   gnt
);

    localparam int LW = $clog2(N_MASTERS);
    localparam int SW = WB_DATA_WIDTH / 8;

    if (N_MASTERS < 2 || N_MASTERS > 8 || (WB_DATA_WIDTH % 8) != 0 ||
        TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("wb_arbiter_rr: illegal parameter set");
    end

`ifdef WB_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, TIMEOUT} state_t;
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

    state_t               state_q, state_d;
    logic [N_MASTERS-1:0] gnt_q, gnt_d;
    logic [LW-1:0]        gidx_q, gidx_d;
    logic [LW-1:0]        last_q, last_d;
    logic [LW-1:0]        pick_idx;
    logic [LW-1:0]        cand;
    logic                 pick_hit;

    assign gnt     = gnt_q;
    assign m_dat_r = s_dat_r;

    // Search upward from the slot after the last winner, wrapping mod N.
    always_comb begin
        pick_idx = '0;
        pick_hit = 1'b0;
        cand     = last_q;
        for (int k = 0; k < N_MASTERS; k++) begin
            cand = (cand == LW'(N_MASTERS - 1)) ? '0 : cand + 1'b1;
            if (!pick_hit && m_cyc[cand]) begin
                pick_hit = 1'b1;
                pick_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        gidx_d  = gidx_q;
        last_d  = last_q;
`ifdef WB_ARB_TIMEOUT_EN
        cnt_d   = '0;
`endif
        s_cyc   = 1'b0;
        s_stb   = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        s_cti   = '0;
        s_bte   = '0;
        m_ack   = '0;
        m_err   = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_hit) begin
                    state_d = BUSY;
                    gidx_d  = pick_idx;
                    gnt_d   = {{(N_MASTERS-1){1'b0}}, 1'b1} << pick_idx;
                end
            end
            BUSY: begin
                s_cyc   = m_cyc[gidx_q];
                s_stb   = m_stb[gidx_q];
                s_we    = m_we[gidx_q];
                s_adr   = m_adr[int'(gidx_q)*WB_ADDR_WIDTH +: WB_ADDR_WIDTH];
                s_dat_w = m_dat_w[int'(gidx_q)*WB_DATA_WIDTH +: WB_DATA_WIDTH];
                s_sel   = m_sel[int'(gidx_q)*SW +: SW];
                s_cti   = m_cti[int'(gidx_q)*3 +: 3];
                s_bte   = m_bte[int'(gidx_q)*2 +: 2];
                m_ack   = gnt_q & {N_MASTERS{s_ack}};
                m_err   = gnt_q & {N_MASTERS{s_err}};
                if (!m_cyc[gidx_q]) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    last_d  = gidx_q;
                end
`ifdef WB_ARB_TIMEOUT_EN
                else if (s_stb && !s_ack && !s_err) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CW'(TIMEOUT_CYCLES)) begin
                        state_d = TIMEOUT;
                    end
                end
`endif
            end
`ifdef WB_ARB_TIMEOUT_EN
            TIMEOUT: begin
                // Slave is cut off for this cycle; master sees one ERR beat.
                m_err   = gnt_q;
                state_d = BUSY;
            end
`endif
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            gidx_q  <= '0;
            last_q  <= LW'(N_MASTERS - 1);
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            gidx_q  <= gidx_d;
            last_q  <= last_d;
`ifdef WB_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule
